// File: rtl/freq_gate_counter.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// fixed window of GATE_CYCLES clocks and publishes a saturated result per gate.
module freq_gate_counter #(
    parameter int GATE_CYCLES = 50000000,
    parameter int CNT_W       = 27
) (
    input  logic             clk_50m,
    input  logic             sys_rst_n,
    input  logic             en,
    input  logic             sig_in,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             ovf,
    output logic             gate_busy
);

    localparam int              GW        = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0]   GATE_LAST = GW'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        IDLE = 1'b0,
        GATE = 1'b1
    } state_t;

    state_t           state;
    logic [GW-1:0]    gate_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic             sat_flag;
    logic             s1, s2, s3;
    logic             rise;
    logic             terminal;
    logic             at_max;
    logic             inc_sat;
    logic [CNT_W-1:0] final_cnt;
    logic             final_ovf;

    // NOTE: non-blocking assignments make each flop take its neighbour's
    // pre-edge value, so s1->s2->s3 behaves as a real shift chain.
    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise     = s2 & ~s3;
    assign terminal = (state == GATE) && (gate_cnt == GATE_LAST);
    assign at_max   = (edge_cnt == CNT_MAX);
    assign inc_sat  = rise & at_max;

    // The terminal-cycle edge is folded in here so it lands in the ending gate.
    assign final_cnt = inc_sat ? CNT_MAX : edge_cnt + CNT_W'(rise);
    assign final_ovf = sat_flag | inc_sat;

    always_ff @(posedge clk_50m or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat_flag   <= 1'b0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            ovf        <= 1'b0;
            gate_busy  <= 1'b0;
        end else begin
            freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    gate_cnt <= '0;
                    edge_cnt <= '0;
                    sat_flag <= 1'b0;
                    if (en) begin
                        state     <= GATE;
                        gate_busy <= 1'b1;
                    end
                end
                GATE: begin
                    if (terminal) begin
                        freq_out   <= final_cnt;
                        ovf        <= final_ovf;
                        freq_valid <= 1'b1;
                        gate_cnt   <= '0;
                        edge_cnt   <= '0;
                        sat_flag   <= 1'b0;
                        if (!en) begin
                            state     <= IDLE;
                            gate_busy <= 1'b0;
                        end
                    end else if (!en) begin
                        // Abort: partial count is dropped, published result kept.
                        state     <= IDLE;
                        gate_busy <= 1'b0;
                        gate_cnt  <= '0;
                        edge_cnt  <= '0;
                        sat_flag  <= 1'b0;
                    end else begin
                        gate_cnt <= gate_cnt + GW'(1);
                        if (rise) begin
                            if (at_max) begin
                                sat_flag <= 1'b1;
                            end else begin
                                edge_cnt <= edge_cnt + CNT_W'(1);
                            end
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    gate_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_gate_counter.sv
// Directed bench for freq_gate_counter with a 100-cycle gate and a 4-bit result
// so that saturation is reachable in a single gate.
module tb_freq_gate_counter;

    localparam int GATE_CYCLES = 100;
    localparam int CNT_W       = 4;

    logic             clk_50m;
    logic             sys_rst_n;
    logic             en;
    logic             sig_in;
    logic [CNT_W-1:0] freq_out;
    logic             freq_valid;
    logic             ovf;
    logic             gate_busy;

    int n_pass  = 0;
    int n_total = 0;

    // Periodic source: 0 means sig_in is driven directly by the main sequence.
    int gen_period = 0;
    int gen_phase  = 0;

    freq_gate_counter #(
        .GATE_CYCLES(GATE_CYCLES),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_50m   (clk_50m),
        .sys_rst_n (sys_rst_n),
        .en        (en),
        .sig_in    (sig_in),
        .freq_out  (freq_out),
        .freq_valid(freq_valid),
        .ovf       (ovf),
        .gate_busy (gate_busy)
    );

    initial clk_50m = 1'b0;
    always #5 clk_50m = ~clk_50m;

    always begin
        @(negedge clk_50m);
        #1;
        if (gen_period != 0) begin
            sig_in    = (gen_phase < gen_period / 2);
            gen_phase = (gen_phase + 1) % gen_period;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic wait_valid(input string tag, input int budget, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk_50m);
            cycles++;
        end while (freq_valid !== 1'b1 && cycles < budget);
        check(tag, 32'(freq_valid), 32'd1);
    endtask

    initial begin
        int c;
        int drops;
        int pulses;
        int cnt_a, cnt_b, cnt_c;

        sys_rst_n = 1'b0;
        en        = 1'b0;
        sig_in    = 1'b0;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;

        // Reset state.
        repeat (3) @(negedge clk_50m);
        check("rst_freq_out",   32'(freq_out),   32'd0);
        check("rst_freq_valid", 32'(freq_valid), 32'd0);
        check("rst_ovf",        32'(ovf),        32'd0);
        check("rst_gate_busy",  32'(gate_busy),  32'd0);

        // Period-10 source, en held: 1 IDLE cycle + 100-cycle gate, then 10 edges.
        @(negedge clk_50m);
        en         = 1'b1;
        gen_phase  = 0;
        gen_period = 10;
        sys_rst_n  = 1'b1;
        wait_valid("first_valid_seen", 300, c);
        check("first_valid_latency", 32'(c), 32'd101);
        check("p10_freq_out", 32'(freq_out), 32'd10);
        check("p10_ovf",      32'(ovf),      32'd0);
        @(negedge clk_50m);
        check("valid_one_cycle", 32'(freq_valid), 32'd0);
        check("busy_no_dead",    32'(gate_busy),  32'd1);
        wait_valid("p10_second_seen", 300, c);
        check("valid_period", 32'(c + 1), 32'd100);
        check("p10_second_freq", 32'(freq_out), 32'd10);
        check("p10_second_ovf",  32'(ovf),      32'd0);

        // Constant-high input: a full gate afterwards counts nothing.
        gen_period = 0;
        sig_in     = 1'b1;
        wait_valid("const_transition_seen", 300, c);
        c     = 0;
        drops = 0;
        do begin
            @(negedge clk_50m);
            c++;
            if (gate_busy !== 1'b1) drops++;
        end while (freq_valid !== 1'b1 && c < 300);
        check("const_gate_len",  32'(c),        32'd100);
        check("const_busy_drop", 32'(drops),    32'd0);
        check("const_freq_out",  32'(freq_out), 32'd0);

        // Re-establish 10 from a full gate, then abort at gate_cnt=50.
        gen_phase  = 0;
        gen_period = 10;
        wait_valid("reprime_seen", 300, c);
        wait_valid("prior10_seen", 300, c);
        check("prior10_freq", 32'(freq_out), 32'd10);
        repeat (50) @(negedge clk_50m);
        en = 1'b0;
        @(negedge clk_50m);
        check("abort_busy_low", 32'(gate_busy), 32'd0);
        pulses = 0;
        repeat (150) begin
            @(negedge clk_50m);
            if (freq_valid === 1'b1) pulses++;
        end
        check("abort_no_valid", 32'(pulses),   32'd0);
        check("abort_freq_kept", 32'(freq_out), 32'd10);
        check("abort_ovf_kept",  32'(ovf),      32'd0);

        // Period-4 source gives 25 edges: saturates at 15 in 4 bits.
        gen_phase  = 0;
        gen_period = 4;
        repeat (10) @(negedge clk_50m);
        en = 1'b1;
        wait_valid("sat_seen", 300, c);
        check("sat_freq_out", 32'(freq_out), 32'd15);
        check("sat_ovf",      32'(ovf),      32'd1);
        repeat (30) @(negedge clk_50m);
        check("sat_stable_mid_gate", 32'(freq_out), 32'd15);
        en = 1'b0;
        repeat (5) @(negedge clk_50m);
        check("sat_kept_after_abort", 32'(freq_out), 32'd15);
        check("ovf_kept_after_abort", 32'(ovf),      32'd1);
        gen_phase  = 0;
        gen_period = 10;
        repeat (10) @(negedge clk_50m);
        en = 1'b1;
        wait_valid("unsat_seen", 300, c);
        check("unsat_freq_out", 32'(freq_out), 32'd10);
        check("unsat_ovf",      32'(ovf),      32'd0);

        // Reset pulsed at gate_cnt=60: outputs clear at once.
        repeat (60) @(negedge clk_50m);
        sys_rst_n  = 1'b0;
        gen_period = 0;
        sig_in     = 1'b0;
        #1;
        check("midrst_freq_out",   32'(freq_out),   32'd0);
        check("midrst_freq_valid", 32'(freq_valid), 32'd0);
        check("midrst_ovf",        32'(ovf),        32'd0);
        check("midrst_gate_busy",  32'(gate_busy),  32'd0);
        repeat (3) @(negedge clk_50m);
        gen_phase  = 0;
        gen_period = 10;
        sys_rst_n  = 1'b1;
        wait_valid("postrst_seen", 300, c);
        check("postrst_latency", 32'(c),        32'd101);
        check("postrst_freq",    32'(freq_out), 32'd10);

        // Hand-placed edges around gate boundaries; n counts negedges from a valid.
        gen_period = 0;
        sig_in     = 1'b0;
        wait_valid("edge_align_seen", 300, c);
        for (int n = 2; n <= 301; n++) begin
            @(negedge clk_50m);
            if (n == 101) begin
                check("gate_a_valid", 32'(freq_valid), 32'd1);
                cnt_a = int'(freq_out);
            end
            if (n == 201) begin
                check("gate_b_valid", 32'(freq_valid), 32'd1);
                cnt_b = int'(freq_out);
            end
            if (n == 301) begin
                check("gate_c_valid", 32'(freq_valid), 32'd1);
                cnt_c = int'(freq_out);
            end
            // Edge at 98 rises in the terminal cycle; edge at 199 in the next gate's first.
            case (n)
                10, 30, 98, 120, 150, 199: sig_in = 1'b1;
                13, 33, 100, 123, 153, 202: sig_in = 1'b0;
                default: ;
            endcase
        end
        check("gate_a_count", 32'(cnt_a), 32'd3);
        check("gate_b_count", 32'(cnt_b), 32'd2);
        check("gate_c_count", 32'(cnt_c), 32'd1);
        check("edge_sum",     32'(cnt_a + cnt_b + cnt_c), 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/freq_gate_counter.md
FREQ_GATE_COUNTER -- requirements
Module: freq_gate_counter

Interface
REQ-001 The module SHALL have parameter GATE_CYCLES, default 50000000, meaning the gate length in clk_50m cycles (1 s at 50 MHz); legal range 2 and above.
REQ-002 The module SHALL have parameter CNT_W, default 27, meaning the width of the frequency result; legal range 4 to 32.
REQ-003 The module SHALL have port clk_50m, input, 1 bit: system clock, all logic on its rising edge.
REQ-004 The module SHALL have port sys_rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The module SHALL have port en, input, 1 bit: measurement enable, synchronous to clk_50m.
REQ-006 The module SHALL have port sig_in, input, 1 bit: measured signal, asynchronous to clk_50m.
REQ-007 The module SHALL have port freq_out, output, CNT_W bits: last completed gate result, in rising edges per gate; it drives the display's 27-bit frequency data input.
REQ-008 The module SHALL have port freq_valid, output, 1 bit: one-cycle pulse when freq_out updates.
REQ-009 The module SHALL have port ovf, output, 1 bit: freq_out holds a saturated value.
REQ-010 The module SHALL have port gate_busy, output, 1 bit: high while the FSM is in GATE.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer (s1, s2) plus a delay flop s3; rise = s2 AND NOT s3.
REQ-012 The latency from a sig_in rising edge, captured at clock k, to rise SHALL be 2 cycles (rise high in cycle k+2).
REQ-013 The FSM SHALL have 2 states, IDLE and GATE; gate_busy SHALL be 1 exactly in GATE.
REQ-014 In IDLE, gate_cnt and edge_cnt SHALL be held at 0; when en = 1 the FSM SHALL go to GATE on the next edge.
REQ-015 In GATE, gate_cnt SHALL increment by 1 each cycle starting from 0; edge_cnt SHALL increment by 1 in each cycle with rise = 1.
REQ-016 The gate SHALL be exactly GATE_CYCLES cycles long: terminal cycle is gate_cnt = GATE_CYCLES-1; the rise seen in the terminal cycle SHALL be counted.
REQ-017 On the edge ending the terminal cycle, the block SHALL do all of the following together:
  - freq_out <= edge_cnt + rise, saturated;
  - ovf <= saturation flag for this gate;
  - freq_valid <= 1;
  - gate_cnt <= 0 and edge_cnt <= 0.
REQ-018 After the terminal cycle the FSM SHALL stay in GATE if en = 1; the next gate SHALL start with no dead cycle, and no edge SHALL be lost or counted twice. If en = 0, the FSM SHALL go to IDLE.
REQ-019 freq_valid SHALL be high for exactly 1 cycle per completed gate, and low otherwise.
REQ-020 Saturation: edge_cnt SHALL stop at 2^CNT_W-1 and SHALL never wrap; a per-gate sticky flag SHALL be set when an increment is attempted at the maximum. The flag SHALL clear at gate start.
REQ-021 If en = 0 during a non-terminal GATE cycle, the gate SHALL be aborted:
  - FSM SHALL go to IDLE on the next edge;
  - counters SHALL clear;
  - freq_out and ovf SHALL retain their previous values;
  - no freq_valid pulse SHALL be produced.
REQ-022 If en falls in the terminal cycle, the gate SHALL complete normally per REQ-017, and the FSM SHALL then go to IDLE.
REQ-023 freq_out and ovf SHALL change only on freq_valid cycles, so the display always sees a stable value.
REQ-024 The maximum measurable sig_in frequency SHALL be clk_50m/2 with a sig_in high and low time of at least 1 clock period each; behaviour above this is undefined.

Reset
REQ-025 While sys_rst_n = 0, the following SHALL apply immediately (asynchronous):
  - freq_out = 0, freq_valid = 0, ovf = 0, gate_busy = 0;
  - FSM in IDLE;
  - gate_cnt, edge_cnt, s1, s2, s3 = 0.
REQ-026 Reset asserted mid-gate SHALL discard the partial count; after release, the first gate SHALL start per REQ-014 if en = 1.
REQ-027 Reset deassertion SHALL be synchronized externally; the block SHALL add no extra synchronizer on sys_rst_n.

Verification
REQ-028 With GATE_CYCLES=100 and en=1 held, sig_in with period 10 clocks (5 high, 5 low) SHALL give freq_out=10, a freq_valid pulse every 100 cycles, and ovf=0.
REQ-029 With GATE_CYCLES=100 and sig_in held at constant 1, freq_out SHALL be 0 after the first gate, and gate_busy SHALL stay 1 throughout.
REQ-030 With GATE_CYCLES=100, freq_out=10 from a prior gate, and en dropped at gate_cnt=50, there SHALL be no freq_valid pulse, freq_out SHALL stay 10, and gate_busy SHALL be 0 one cycle later.
REQ-031 With CNT_W=4, GATE_CYCLES=100 and sig_in period 4 clocks (25 edges), freq_out SHALL be 15 with ovf=1; the next gate at period 10 SHALL give freq_out=10 with ovf=0.
REQ-032 With sys_rst_n pulsed low at gate_cnt=60, all outputs SHALL be 0 immediately; the first freq_valid after release SHALL occur 101 cycles after release (1 IDLE cycle plus a 100-cycle gate) with a full-gate count.
REQ-033 With a sig_in edge placed so that rise falls in the terminal cycle, that edge SHALL be counted in the ending gate and not in the next; the sum over consecutive gates SHALL equal the total edges applied.
